lift_scan_ctrl: RTL and testbench

Parametrised multi-request elevator controller, successor to the single-target lift controller. It holds a bitmap of pending floor requests and serves them in SCAN order, continuing in the current direction while requests remain ahead, then reversing. Per-floor travel time and door dwell are programmable cycle counts, and a request for the current floor re-opens or extends the door. It sits between the hall/car request encoder and the motor/door drivers.

---
 rtl/lift_pkg.sv | 20 ++
 rtl/lift_pending_scan.sv | 23 ++
 rtl/lift_scan_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_lift_scan_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/lift_pkg.sv
// Shared types and constants for the lift controller family.
package lift_pkg;

  // Controller phase: parked, travelling between floors, or door open.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
  } state_t;

  // Direction of travel; kept while parked so SCAN keeps its sweep order.
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  // Home floor the car returns to on reset.
  localparam int RESET_FLOOR = 0;

endpackage

// File: rtl/lift_pending_scan.sv
// Reports whether any outstanding request lies above or below a floor.
// Purely combinational so several cars can share the same helper.
module lift_pending_scan #(
  parameter int FLOORS = 40,
  parameter int FW     = 7
) (
  input  logic [FLOORS-1:0] pending,
  input  logic [FW-1:0]     y,
  output logic              above,
  output logic              below
);

  // Walk the bitmap once and flag requests on either side of the car.
  always_comb begin
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if (pending[i] && (i > int'(y))) above = 1'b1;
      if (pending[i] && (i < int'(y))) below = 1'b1;
    end
  end

endmodule

// File: rtl/lift_scan_ctrl.sv
// Multi-request SCAN elevator controller.
// Holds a bitmap of floor requests and sweeps in one direction while
// requests remain ahead, then reverses. One shared timer counts either
// per-floor travel or door dwell, since the two never overlap.
//
// Request interface: req_valid is a strobe with no back-pressure; a
// request is taken on every rising edge where req_valid is high, and
// req_floor must be stable alongside it. Out-of-range floors are dropped
// and flagged by a one-cycle req_err pulse on the following cycle.
module lift_scan_ctrl
  import lift_pkg::*;
#(
  parameter int FLOORS     = 40,
  parameter int FW         = 7,
  parameter int TRAVEL_CYC = 4,
  parameter int DOOR_CYC   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [FW-1:0]     req_floor,
  output logic              req_err,
  output logic [FW-1:0]     y,
  output logic              Up,
  output logic              Down,
  output logic              stop,
  output logic              door,
  output logic [FLOORS-1:0] pending,
  output logic [1:0]        fsm_state
);

  // Timer is sized for the longer of the two intervals it times.
  localparam int MAX_CYC = (TRAVEL_CYC > DOOR_CYC) ? TRAVEL_CYC : DOOR_CYC;
  localparam int TW      = $clog2(MAX_CYC) + 1;

  localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_CYC - 1);
  localparam logic [TW-1:0] DOOR_LOAD   = TW'(DOOR_CYC - 1);
  localparam logic [FW-1:0] TOP_FLOOR   = FW'(FLOORS - 1);
  localparam logic [FW-1:0] HOME_FLOOR  = FW'(RESET_FLOOR);

  state_t            state, state_nx;
  dir_t              dir, dir_nx;
  logic [FW-1:0]     y_nx;
  logic [TW-1:0]     timer, timer_nx;
  logic [FLOORS-1:0] pending_nx;
  logic              req_err_nx;

  logic              above, below;
  logic              ahead, behind;
  logic              in_range;
  logic              door_restart;
  logic              can_step;
  logic [FW-1:0]     step_y;
  logic              arrive_stop;
  logic [FLOORS-1:0] req_mask;
  logic [FLOORS-1:0] clr_mask;
  logic [FLOORS-1:0] set_mask;

  // One-hot mask for a floor index.
  function automatic logic [FLOORS-1:0] floor_bit(input logic [FW-1:0] f);
    return FLOORS'(1) << f;
  endfunction

  lift_pending_scan #(
    .FLOORS (FLOORS),
    .FW     (FW)
  ) u_scan (
    .pending (pending),
    .y       (y),
    .above   (above),
    .below   (below)
  );

  // Request qualification and the candidate floor for the next step.
  always_comb begin
    in_range     = int'(req_floor) < FLOORS;
    req_mask     = (req_valid && in_range) ? floor_bit(req_floor) : '0;
    door_restart = (state == DOOR) && req_valid && in_range && (req_floor == y);
    ahead        = (dir == DIR_UP) ? above : below;
    behind       = (dir == DIR_UP) ? below : above;
    can_step     = (dir == DIR_UP) ? (y != TOP_FLOOR) : (y != HOME_FLOOR);
    step_y       = (dir == DIR_UP) ? (y + 1'b1) : (y - 1'b1);
    // A step lands at a stop if that floor was pending or is being
    // requested on this very edge.
    arrive_stop  = ((pending & floor_bit(step_y)) != '0) ||
                   (req_valid && in_range && (req_floor == step_y));
  end

  // State register plus the datapath registers it steers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      dir     <= DIR_UP;
      y       <= HOME_FLOOR;
      timer   <= '0;
      pending <= '0;
      req_err <= 1'b0;
    end else begin
      state   <= state_nx;
      dir     <= dir_nx;
      y       <= y_nx;
      timer   <= timer_nx;
      pending <= pending_nx;
      req_err <= req_err_nx;
    end
  end

  // Next-state decision: SCAN scheduling, timer control, bitmap update.
  always_comb begin
    state_nx   = state;
    dir_nx     = dir;
    y_nx       = y;
    timer_nx   = timer;
    clr_mask   = '0;
    req_err_nx = req_valid && !in_range;

    case (state)
      IDLE: begin
        if ((pending & floor_bit(y)) != '0) begin
          state_nx = DOOR;
          timer_nx = DOOR_LOAD;
          clr_mask = floor_bit(y);
        end else if (ahead) begin
          state_nx = MOVE;
          timer_nx = TRAVEL_LOAD;
        end else if (behind) begin
          dir_nx   = (dir == DIR_UP) ? DIR_DOWN : DIR_UP;
          state_nx = MOVE;
          timer_nx = TRAVEL_LOAD;
        end
      end

      MOVE: begin
        if (timer != '0) begin
          timer_nx = timer - 1'b1;
        end else if (can_step) begin
          y_nx = step_y;
          if (arrive_stop) begin
            state_nx = DOOR;
            timer_nx = DOOR_LOAD;
            clr_mask = floor_bit(step_y);
          end else begin
            timer_nx = TRAVEL_LOAD;
          end
        end else begin
          // Defensive: the sweep never targets past the shaft ends, but
          // if it did, park rather than run off the end.
          state_nx = IDLE;
        end
      end

      DOOR: begin
        if (door_restart) begin
          timer_nx = DOOR_LOAD;
        end else if (timer != '0) begin
          timer_nx = timer - 1'b1;
        end else if (ahead) begin
          state_nx = MOVE;
          timer_nx = TRAVEL_LOAD;
        end else if (behind) begin
          dir_nx   = (dir == DIR_UP) ? DIR_DOWN : DIR_UP;
          state_nx = MOVE;
          timer_nx = TRAVEL_LOAD;
        end else begin
          state_nx = IDLE;
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase

    // A request for a floor being served on this edge is absorbed; a
    // request for the open-door floor only extends the dwell.
    set_mask   = door_restart ? '0 : (req_mask & ~clr_mask);
    pending_nx = (pending & ~clr_mask) | set_mask;
  end

  // Motor/door outputs decoded from registered state only.
  always_comb begin
    Up        = (state == MOVE) && (dir == DIR_UP);
    Down      = (state == MOVE) && (dir == DIR_DOWN);
    stop      = (state != MOVE);
    door      = (state == DOOR);
    fsm_state = state;
  end

endmodule

// File: tb/tb_lift_scan_ctrl.sv
// Directed bench for lift_scan_ctrl at default parameters.
module tb_lift_scan_ctrl;
  import lift_pkg::*;

  localparam int FLOORS = 40;
  localparam int FW     = 7;

  logic              clk;
  logic              reset;
  logic              req_valid;
  logic [FW-1:0]     req_floor;
  logic              req_err;
  logic [FW-1:0]     y;
  logic              Up;
  logic              Down;
  logic              stop;
  logic              door;
  logic [FLOORS-1:0] pending;
  logic [1:0]        fsm_state;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int fail_cnt = 0;

  lift_scan_ctrl #(
    .FLOORS     (40),
    .FW         (7),
    .TRAVEL_CYC (4),
    .DOOR_CYC   (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_floor (req_floor),
    .req_err   (req_err),
    .y         (y),
    .Up        (Up),
    .Down      (Down),
    .stop      (stop),
    .door      (door),
    .pending   (pending),
    .fsm_state (fsm_state)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic steps(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present a request so it is sampled on the next edge.
  task automatic request(input logic [FW-1:0] f);
    req_valid = 1'b1;
    req_floor = f;
    steps(1);
    req_valid = 1'b0;
    req_floor = '0;
  endtask

  function automatic logic [63:0] bits(input int a);
    logic [63:0] one;
    one = 64'd1;
    return one << a;
  endfunction

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_floor = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset values
    chk("rst_y",       64'(y),         64'd0);
    chk("rst_stop",    64'(stop),      64'd1);
    chk("rst_up",      64'(Up),        64'd0);
    chk("rst_down",    64'(Down),      64'd0);
    chk("rst_door",    64'(door),      64'd0);
    chk("rst_pending", 64'(pending),   64'd0);
    chk("rst_req_err", 64'(req_err),   64'd0);
    chk("rst_state",   64'(fsm_state), 64'(IDLE));

    // Single request to 25 from floor 0 (edge 0)
    request(7'd25);
    chk("s25_pend_e0",  64'(pending),   bits(25));
    chk("s25_state_e0", 64'(fsm_state), 64'(IDLE));
    steps(1);                                   // edge 1
    chk("s25_up_e1",    64'(Up),        64'd1);
    chk("s25_stop_e1",  64'(stop),      64'd0);
    steps(4);                                   // edge 5
    chk("s25_y_e5",     64'(y),         64'd1);
    steps(95);                                  // edge 100
    chk("s25_y_e100",   64'(y),         64'd24);
    chk("s25_door_e100",64'(door),      64'd0);
    steps(1);                                   // edge 101
    chk("s25_y_e101",   64'(y),         64'd25);
    chk("s25_door_e101",64'(door),      64'd1);
    chk("s25_pend_e101",64'(pending),   64'd0);
    chk("s25_up_e101",  64'(Up),        64'd0);
    steps(7);                                   // edge 108
    chk("s25_door_e108",64'(door),      64'd1);
    steps(1);                                   // edge 109
    chk("s25_door_e109",64'(door),      64'd0);
    chk("s25_stop_e109",64'(stop),      64'd1);
    chk("s25_idle_e109",64'(fsm_state), 64'(IDLE));

    // Reset mid-MOVE: head down from 25 to 0, reset at y=12
    request(7'd0);                              // edge 0
    steps(1);                                   // edge 1
    chk("rm_down_e1",   64'(Down),      64'd1);
    steps(52);                                  // edge 53
    chk("rm_y_e53",     64'(y),         64'd12);
    chk("rm_down_e53",  64'(Down),      64'd1);
    reset = 1'b1;
    #2;
    chk("rm_y",         64'(y),         64'd0);
    chk("rm_stop",      64'(stop),      64'd1);
    chk("rm_down",      64'(Down),      64'd0);
    chk("rm_up",        64'(Up),        64'd0);
    chk("rm_door",      64'(door),      64'd0);
    chk("rm_pending",   64'(pending),   64'd0);
    reset = 1'b0;
    steps(1);
    chk("rm_idle",      64'(fsm_state), 64'(IDLE));

    // SCAN order: toward 37, inject 3 and 20 while passing floor 10
    request(7'd37);                             // edge 0
    steps(41);                                  // edge 41
    chk("scan_y_e41",   64'(y),         64'd10);
    request(7'd3);                              // edge 42
    request(7'd20);                             // edge 43
    chk("scan_pend_e43",64'(pending),   bits(3) | bits(20) | bits(37));
    steps(37);                                  // edge 80
    chk("scan_door_e80",64'(door),      64'd0);
    steps(1);                                   // edge 81
    chk("scan_y_e81",   64'(y),         64'd20);
    chk("scan_door_e81",64'(door),      64'd1);
    chk("scan_pend_e81",64'(pending),   bits(3) | bits(37));
    steps(7);                                   // edge 88
    chk("scan_door_e88",64'(door),      64'd1);
    steps(1);                                   // edge 89
    chk("scan_up_e89",  64'(Up),        64'd1);
    steps(68);                                  // edge 157
    chk("scan_y_e157",  64'(y),         64'd37);
    chk("scan_door_e157",64'(door),     64'd1);
    chk("scan_pend_e157",64'(pending),  bits(3));
    steps(8);                                   // edge 165
    chk("scan_down_e165",64'(Down),     64'd1);
    steps(136);                                 // edge 301
    chk("scan_y_e301",  64'(y),         64'd3);
    chk("scan_door_e301",64'(door),     64'd1);
    chk("scan_pend_e301",64'(pending),  64'd0);

    // Door extend: request 3 at dwell cycle 6 (edge 307)
    steps(5);                                   // edge 306
    request(7'd3);                              // edge 307
    chk("ext_pend_e307",64'(pending),   64'd0);
    chk("ext_door_e307",64'(door),      64'd1);
    steps(2);                                   // edge 309, old close point
    chk("ext_door_e309",64'(door),      64'd1);
    steps(5);                                   // edge 314
    chk("ext_door_e314",64'(door),      64'd1);
    chk("ext_pend_e314",64'(pending),   64'd0);
    steps(1);                                   // edge 315
    chk("ext_door_e315",64'(door),      64'd0);
    chk("ext_idle_e315",64'(fsm_state), 64'(IDLE));

    // Out-of-range request
    request(7'd45);
    chk("oor_err",      64'(req_err),   64'd1);
    chk("oor_pend",     64'(pending),   64'd0);
    chk("oor_state",    64'(fsm_state), 64'(IDLE));
    steps(1);
    chk("oor_err_clr",  64'(req_err),   64'd0);
    chk("oor_state2",   64'(fsm_state), 64'(IDLE));

    // Arrival collision at floor 5 while heading from 3 to 10
    request(7'd10);                             // edge 0
    steps(8);                                   // edge 8
    chk("col_y_e8",     64'(y),         64'd4);
    request(7'd5);                              // edge 9, arrival at 5
    chk("col_y_e9",     64'(y),         64'd5);
    chk("col_door_e9",  64'(door),      64'd1);
    chk("col_pend_e9",  64'(pending),   bits(10));
    steps(8);                                   // edge 17
    chk("col_up_e17",   64'(Up),        64'd1);
    steps(4);                                   // edge 21
    chk("col_y_e21",    64'(y),         64'd6);
    chk("col_door_e21", 64'(door),      64'd0);
    chk("col_pend_e21", 64'(pending),   bits(10));
    steps(16);                                  // edge 37
    chk("col_y_e37",    64'(y),         64'd10);
    chk("col_door_e37", 64'(door),      64'd1);
    steps(8);                                   // edge 45
    chk("col_stop_e45", 64'(stop),      64'd1);
    chk("col_door_e45", 64'(door),      64'd0);

    // Request for the current floor while parked: door at edge 1
    request(7'd10);                             // edge 0
    chk("cur_pend_e0",  64'(pending),   bits(10));
    chk("cur_door_e0",  64'(door),      64'd0);
    steps(1);                                   // edge 1
    chk("cur_door_e1",  64'(door),      64'd1);
    chk("cur_pend_e1",  64'(pending),   64'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
